// File: rtl/mux_rr_arbiter.sv
// Round-robin owner arbiter for a shared 8:1 bit mux.
// Owner holds until it drops req or HOLD_MAX cycles elapse.
module mux_rr_arbiter #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] selector,
  output logic       sel_valid,
  output logic       timeout,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    GAP
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] grant_d;
  logic [2:0] sel_d;
  logic       vld_d;
  logic       to_d;

  logic [2:0] win;
  logic [2:0] idx;
  logic       found;
  logic       drop;
  logic       limit;

  // Rotating priority search starting at ptr.
  always_comb begin
    win   = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr_q + 3'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign drop  = !req[selector];
  assign limit = (cnt_q == HOLD_LAST);

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant;
    sel_d   = selector;
    vld_d   = sel_valid;
    to_d    = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (found) begin
          grant_d = 8'd1 << win;
          sel_d   = win;
          vld_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = OWN;
        end
      end
      (state_q == OWN): begin
        if (drop || limit) begin
          grant_d = 8'd0;
          vld_d   = 1'b0;
          ptr_d   = selector + 3'd1;
          to_d    = !drop;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      (state_q == GAP): begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      cnt_q     <= 8'd0;
      grant     <= 8'd0;
      selector  <= 3'd0;
      sel_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      grant     <= grant_d;
      selector  <= sel_d;
      sel_valid <= vld_d;
      timeout   <= to_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter.
// Reference model tracks owner, hold count and cooldown.
module tb_mux_rr_arbiter;

  localparam int HM = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'd0;
  logic [7:0] grant;
  logic [2:0] selector;
  logic       sel_valid;
  logic       timeout;
  logic       busy;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.HOLD_MAX(HM)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .grant    (grant),
    .selector (selector),
    .sel_valid(sel_valid),
    .timeout  (timeout),
    .busy     (busy)
  );

  typedef struct packed {
    logic [7:0] grant;
    logic [2:0] sel;
    logic       vld;
    logic       to;
    logic       busy;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  int m_owner = -1;
  int m_sel   = 0;
  int m_ptr   = 0;
  int m_used  = 0;
  int m_cool  = 0;
  bit m_to    = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_sel   = 0;
    m_ptr   = 0;
    m_used  = 0;
    m_cool  = 0;
    m_to    = 1'b0;
  endtask

  // One clock edge of the arbitration rules.
  task automatic model_step(input logic [7:0] r);
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_cool  = 1;
      end else if (m_used + 1 == HM) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_cool  = 1;
        m_to    = 1'b1;
      end else begin
        m_used++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % 8]) begin
          m_owner = (m_ptr + k) % 8;
          m_sel   = m_owner;
          m_used  = 0;
        end
      end
    end
  endtask

  task automatic apply(input logic [7:0] r);
    exp_t e;
    req = r;
    model_step(r);
    e.grant = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
    e.sel   = 3'(m_sel);
    e.vld   = (m_owner >= 0);
    e.to    = m_to;
    e.busy  = (m_owner >= 0) || (m_cool > 0);
    sbq.push_back(e);
  endtask

  task automatic drive(input logic [7:0] r);
    @(negedge clk);
    apply(r);
  endtask

  task automatic drive_n(input logic [7:0] r, input int n);
    for (int i = 0; i < n; i++) drive(r);
  endtask

  // Monitor: compare the DUT after each edge with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("grant", 32'(grant), 32'(e.grant));
        check("selector", 32'(selector), 32'(e.sel));
        check("sel_valid", 32'(sel_valid), 32'(e.vld));
        check("timeout", 32'(timeout), 32'(e.to));
        check("busy", 32'(busy), 32'(e.busy));
      end
    end
  end

  initial begin
    logic [7:0] pat;
    rst_n = 1'b0;
    req   = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_sel", 32'(selector), 32'd0);
    check("rst_vld", 32'(sel_valid), 32'd0);
    check("rst_to", 32'(timeout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    model_reset();

    // Single requester dropping after three owned cycles.
    drive_n(8'h20, 3);
    drive_n(8'h00, 3);
    // Everyone requesting: forced releases in rotation.
    drive_n(8'hFF, 60);
    drive_n(8'h00, 3);
    // Wrap from 7 to 0.
    drive_n(8'h40, 2);
    drive_n(8'h81, 20);
    drive_n(8'h00, 3);
    // Two requesters sharing under timeouts.
    drive_n(8'h09, 24);
    drive_n(8'h00, 3);
    // Drop on the same edge the hold limit is reached.
    drive_n(8'h01, 3);
    drive_n(8'h00, 3);
    // Non-owner activity while channel 2 owns.
    drive(8'h04);
    drive(8'h0C);
    drive(8'h06);
    drive_n(8'h00, 3);

    // Asynchronous reset in the middle of a grant.
    drive(8'h04);
    drive(8'h04);
    @(posedge clk);
    #3;
    check("pre_rst_grant", 32'(grant), 32'h04);
    rst_n = 1'b0;
    #1;
    check("async_grant", 32'(grant), 32'd0);
    check("async_sel", 32'(selector), 32'd0);
    check("async_vld", 32'(sel_valid), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    apply(8'h01);
    drive_n(8'h01, 2);

    // Random traffic, patterns held for a few cycles.
    pat = 8'($urandom);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 4) == 0) pat = 8'($urandom);
      else if ($urandom_range(0, 3) == 0)
        pat = pat ^ (8'd1 << $urandom_range(0, 7));
      drive(pat);
    end
    drive_n(8'h00, 4);
    @(posedge clk);
    #3;
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
